bandai2003_host: RTL and testbench

BANDAI2003_HOST -- requirements
Module: bandai2003_host

---
 rtl/bandai2003_pkg.sv | 34 +++
 rtl/bandai2003_so_rx.sv | 43 ++++
 rtl/bandai2003_host.sv | 230 +++++++++++++++++++++++
 tb/tb_bandai2003_host.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bandai2003_pkg.sv
// Shared constants, FSM states and error codes for the Bandai 2003 cartridge host.
package bandai2003_pkg;

    localparam logic [7:0]  ADDR_ACK   = 8'h5A;
    localparam logic [7:0]  ADDR_NAK   = 8'hA5;
    localparam logic [7:0]  ADDR_NIH   = 8'hFF;
    localparam logic [7:0]  ADDR_LAO   = 8'hC0;
    localparam logic [7:0]  ADDR_RAMB  = 8'hC1;
    localparam logic [7:0]  ADDR_ROMB0 = 8'hC2;
    localparam logic [7:0]  ADDR_ROMB1 = 8'hC3;
    localparam logic [15:0] SIG_WORD   = 16'h28A0;
    localparam int unsigned RX_BITS    = 18;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CRST, ST_ACK, ST_NAK, ST_RX, ST_CHECK, ST_WR, ST_RD, ST_DONE, ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_FRAME    = 2'd1,
        ERR_SIG      = 2'd2,
        ERR_READBACK = 2'd3
    } err_e;

    function automatic logic [7:0] bank_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return ADDR_LAO;
            2'd1:    return ADDR_RAMB;
            2'd2:    return ADDR_ROMB0;
            default: return ADDR_ROMB1;
        endcase
    endfunction

endpackage

// File: rtl/bandai2003_so_rx.sv
// Serial-out capture: 18 samples LSB first, word in samples 1..16, start/stop bits must be 0.
module bandai2003_so_rx
    import bandai2003_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        so_i,
    output logic [15:0] word,
    output logic        frame_ok,
    output logic        last_c
);

    logic [4:0]  cnt_q, cnt_d;
    logic [17:0] sh_q,  sh_d;

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clr) begin
            cnt_d = 5'd0;
        end else if (en) begin
            sh_d  = {so_i, sh_q[17:1]};
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 5'd0;
            sh_q  <= 18'd0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

    assign last_c   = en && (cnt_q == 5'(RX_BITS - 1));
    assign word     = sh_q[16:1];
    assign frame_ok = !sh_q[0] && !sh_q[17];

endmodule

// File: rtl/bandai2003_host.sv
// Cartridge unlock host: reset, ACK/NAK handshake, signature receive, bank-register writes.
// Optional readback of C0..C3 enabled by BANDAI2003_READBACK_EN.
module bandai2003_host
    import bandai2003_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned WE_CYCLES  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] LAO,
    input  logic [7:0] RAMB,
    input  logic [7:0] ROMB0,
    input  logic [7:0] ROMB1,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] ERR,
    output logic       CTRL1_B7,
    output logic       CART_RSTn,
    output logic       CEn,
    output logic       SSn,
    output logic       WEn,
    output logic       OEn,
    output logic [7:0] ADDR,
    output logic [7:0] DQ_O,
    output logic       DQ_OE,
    input  logic [7:0] DQ_I,
    input  logic       SO_I
);

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][7:0] bank_q, bank_d;
    err_e            err_q, err_d;
    logic            ctrl_q, ctrl_d;
    logic            busy_q, busy_d, done_q, done_d, cart_rstn_q, cart_rstn_d;
    logic            cen_q, cen_d, ssn_q, ssn_d, wen_q, wen_d, oen_q, oen_d, dqoe_q, dqoe_d;
    logic [7:0]      addr_q, addr_d, dqo_q, dqo_d;
    logic [15:0]     rx_word;
    logic            rx_frame_ok, rx_last_c;

    bandai2003_so_rx u_so_rx (
        .clk      (CLK),
        .rst      (RST),
        .clr      (state_q == ST_NAK),
        .en       (state_q == ST_RX),
        .so_i     (SO_I),
        .word     (rx_word),
        .frame_ok (rx_frame_ok),
        .last_c   (rx_last_c)
    );

`ifndef BANDAI2003_READBACK_EN
    logic unused_dq_i;
    assign unused_dq_i = ^DQ_I;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 8'd1;
        idx_d       = idx_q;
        bank_d      = bank_q;
        err_d       = err_q;
        ctrl_d      = ctrl_q;
        cart_rstn_d = cart_rstn_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    bank_d  = {ROMB1, ROMB0, RAMB, LAO};
                    err_d   = ERR_NONE;
                    ctrl_d  = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = ST_CRST;
                end
            end
            ST_CRST: if (cnt_q == 8'(RST_CYCLES - 1)) state_d = ST_ACK;
            ST_ACK: begin
                if (SO_I) begin
                    state_d = ST_NAK;
                end else begin
                    err_d   = ERR_FRAME;
                    state_d = ST_ERR;
                end
            end
            ST_NAK:  state_d = ST_RX;
            ST_RX:   if (rx_last_c) state_d = ST_CHECK;
            ST_CHECK: begin
                if (!rx_frame_ok) begin
                    err_d   = ERR_FRAME;
                    state_d = ST_ERR;
                end else if (rx_word != SIG_WORD) begin
                    err_d   = ERR_SIG;
                    state_d = ST_ERR;
                end else begin
                    ctrl_d  = 1'b1;
                    cnt_d   = 8'd0;
                    idx_d   = 2'd0;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (cnt_q == 8'(WE_CYCLES + 1)) begin
                    cnt_d = 8'd0;
                    if (idx_q == 2'd3) begin
`ifdef BANDAI2003_READBACK_EN
                        idx_d   = 2'd0;
                        state_d = ST_RD;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
`ifdef BANDAI2003_READBACK_EN
            ST_RD: begin
                if (cnt_q == 8'd1) begin
                    cnt_d = 8'd0;
                    if (DQ_I != bank_q[idx_q]) begin
                        err_d   = ERR_READBACK;
                        state_d = ST_ERR;
                    end else if (idx_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
`endif
            ST_DONE, ST_ERR: state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
        done_d = (state_d == ST_DONE) || (state_d == ST_ERR);
        if (state_d == ST_CRST)      cart_rstn_d = 1'b0;
        else if (state_q == ST_CRST) cart_rstn_d = 1'b1;

        cen_d  = 1'b1;
        ssn_d  = 1'b1;
        wen_d  = 1'b1;
        oen_d  = 1'b1;
        addr_d = ADDR_NIH;
        dqo_d  = 8'h00;
        dqoe_d = 1'b0;
        case (state_d)
            ST_ACK: begin
                cen_d  = 1'b0;
                addr_d = ADDR_ACK;
            end
            ST_NAK: begin
                cen_d  = 1'b0;
                addr_d = ADDR_NAK;
            end
            ST_RX, ST_CHECK: cen_d = 1'b0;
            ST_WR: begin
                cen_d  = 1'b0;
                ssn_d  = 1'b0;
                dqoe_d = 1'b1;
                addr_d = bank_addr(idx_d);
                dqo_d  = bank_d[idx_d];
                wen_d  = !((cnt_d >= 8'd1) && (cnt_d <= 8'(WE_CYCLES)));
            end
            ST_RD: begin
                cen_d  = 1'b0;
                ssn_d  = 1'b0;
                oen_d  = 1'b0;
                addr_d = bank_addr(idx_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            idx_q       <= 2'd0;
            bank_q      <= '0;
            err_q       <= ERR_NONE;
            ctrl_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cart_rstn_q <= 1'b0;
            cen_q       <= 1'b1;
            ssn_q       <= 1'b1;
            wen_q       <= 1'b1;
            oen_q       <= 1'b1;
            addr_q      <= ADDR_NIH;
            dqo_q       <= 8'h00;
            dqoe_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            bank_q      <= bank_d;
            err_q       <= err_d;
            ctrl_q      <= ctrl_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cart_rstn_q <= cart_rstn_d;
            cen_q       <= cen_d;
            ssn_q       <= ssn_d;
            wen_q       <= wen_d;
            oen_q       <= oen_d;
            addr_q      <= addr_d;
            dqo_q       <= dqo_d;
            dqoe_q      <= dqoe_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign CTRL1_B7  = ctrl_q;
    assign CART_RSTn = cart_rstn_q;
    assign CEn       = cen_q;
    assign SSn       = ssn_q;
    assign WEn       = wen_q;
    assign OEn       = oen_q;
    assign ADDR      = addr_q;
    assign DQ_O      = dqo_q;
    assign DQ_OE     = dqoe_q;

endmodule

// File: tb/tb_bandai2003_host.sv
// Scoreboard bench for bandai2003_host with a behavioural cartridge model.
module tb_bandai2003_host;

    logic       CLK = 1'b0;
    logic       RST, START, SO_I;
    logic [7:0] LAO, RAMB, ROMB0, ROMB1, DQ_I;
    logic       BUSY, DONE, CTRL1_B7, CART_RSTn, CEn, SSn, WEn, OEn, DQ_OE;
    logic [1:0] ERR;
    logic [7:0] ADDR, DQ_O;

    bandai2003_host dut (
        .CLK(CLK), .RST(RST), .START(START), .LAO(LAO), .RAMB(RAMB), .ROMB0(ROMB0), .ROMB1(ROMB1),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CTRL1_B7(CTRL1_B7), .CART_RSTn(CART_RSTn),
        .CEn(CEn), .SSn(SSn), .WEn(WEn), .OEn(OEn), .ADDR(ADDR), .DQ_O(DQ_O), .DQ_OE(DQ_OE),
        .DQ_I(DQ_I), .SO_I(SO_I)
    );

    always #5 CLK = ~CLK;

`ifdef BANDAI2003_READBACK_EN
    localparam int LAT_OK = 49;
`else
    localparam int LAT_OK = 41;
`endif

    typedef struct {
        logic [1:0]  err;
        logic        ctrl;
        int          lat;
        int          nwr;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         wr_total = 0;

    // Cartridge model state
    logic [17:0] frame;
    logic        ack_val;
    logic        rb_corrupt;
    logic [7:0]  prev_addr = 8'hFF;
    int          rx_k = 18;
    logic [7:0]  regs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Cartridge: ACK response, 18-bit serial stream after NAK, register file and readback.
    always @(negedge CLK) begin
        if (prev_addr == 8'hA5 && ADDR != 8'hA5) rx_k = 0;
        if (rx_k < 18) begin
            SO_I = frame[rx_k];
            rx_k++;
        end else if (ADDR == 8'h5A) begin
            SO_I = ack_val;
        end else begin
            SO_I = 1'b0;
        end
        prev_addr = ADDR;
        if (!OEn) DQ_I = (rb_corrupt && ADDR == 8'hC2) ? 8'h00 : regs[ADDR[1:0]];
        else      DQ_I = 8'h00;
    end

    // Monitor: collects writes and checks each DONE against the scoreboard.
    int          t0 = 0, nwr = 0, crst_cnt = 0;
    logic        busy_p = 1'b0, wen_p = 1'b1;
    logic [15:0] obs [8];
    always @(negedge CLK) begin
        exp_t e;
        if (BUSY && !busy_p) begin
            t0 = cyc;
            nwr = 0;
            crst_cnt = 0;
        end
        if (BUSY && !CART_RSTn) crst_cnt++;
        if (WEn && !wen_p) begin
            if (nwr < 8) obs[nwr] = {ADDR, DQ_O};
            regs[ADDR[1:0]] = DQ_O;
            nwr++;
            wr_total++;
        end
        if (DONE) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("err_code", 32'(ERR), 32'(e.err));
                chk("ctrl1_b7", 32'(CTRL1_B7), 32'(e.ctrl));
                chk("latency", 32'(cyc - t0), 32'(e.lat));
                chk("busy_at_done", 32'(BUSY), 32'd0);
                chk("crst_cycles", 32'(crst_cnt), 32'd4);
                chk("write_count", 32'(nwr), 32'(e.nwr));
                for (int i = 0; i < e.nwr && i < nwr; i++)
                    chk("write_addr_data", 32'(obs[i]), 32'({8'hC0 + 8'(i), e.data[8*i +: 8]}));
            end
        end
        busy_p = BUSY;
        wen_p  = WEn;
    end

    task automatic session(input logic [31:0] banks, input logic ack, input logic start_b,
                           input logic [15:0] word, input logic stop_b, input logic corrupt,
                           input int inject_at, input exp_t e);
        int n;
        frame      = {stop_b, word, start_b};
        ack_val    = ack;
        rb_corrupt = corrupt;
        exp_q.push_back(e);
        @(negedge CLK);
        {ROMB1, ROMB0, RAMB, LAO} = banks;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 120) begin
            @(negedge CLK);
            n++;
            if (n == inject_at) begin
                {ROMB1, ROMB0, RAMB, LAO} = 32'hEEDDCCBB;
                START = 1'b1;
            end else begin
                START = 1'b0;
            end
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int w0;
        RST = 1'b1; START = 1'b0; SO_I = 1'b0; DQ_I = 8'h00;
        {ROMB1, ROMB0, RAMB, LAO} = 32'h0;
        frame = 18'd0; ack_val = 1'b1; rb_corrupt = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_cart_rstn", 32'(CART_RSTn), 32'd0);
        chk("rst_bus", 32'({CEn, SSn, WEn, OEn, ADDR, DQ_O, DQ_OE}), 32'({4'hF, 8'hFF, 8'h00, 1'b0}));
        RST = 1'b0;
        @(negedge CLK);

        // Nominal session
        session(32'h78563412, 1'b1, 1'b0, 16'h28A0, 1'b0, 1'b0, -1,
                '{err: 2'd0, ctrl: 1'b1, lat: LAT_OK, nwr: 4, data: 32'h78563412});
        chk("cart_rstn_after", 32'(CART_RSTn), 32'd1);
        // Start-bit fault
        session(32'h78563412, 1'b1, 1'b1, 16'h28A0, 1'b0, 1'b0, -1,
                '{err: 2'd1, ctrl: 1'b0, lat: 25, nwr: 0, data: 32'h0});
        chk("err_hold", 32'(ERR), 32'd1);
        // Stop-bit fault
        session(32'h78563412, 1'b1, 1'b0, 16'h28A0, 1'b1, 1'b0, -1,
                '{err: 2'd1, ctrl: 1'b0, lat: 25, nwr: 0, data: 32'h0});
        // Signature fault
        session(32'h78563412, 1'b1, 1'b0, 16'h28A1, 1'b0, 1'b0, -1,
                '{err: 2'd2, ctrl: 1'b0, lat: 25, nwr: 0, data: 32'h0});
        // Missing ACK response
        session(32'h78563412, 1'b0, 1'b0, 16'h28A0, 1'b0, 1'b0, -1,
                '{err: 2'd1, ctrl: 1'b0, lat: 5, nwr: 0, data: 32'h0});
        // START pulsed during WR with different bank inputs is ignored
        session(32'hD4C3B2A1, 1'b1, 1'b0, 16'h28A0, 1'b0, 1'b0, 30,
                '{err: 2'd0, ctrl: 1'b1, lat: LAT_OK, nwr: 4, data: 32'hD4C3B2A1});
`ifdef BANDAI2003_READBACK_EN
        session(32'h78563412, 1'b1, 1'b0, 16'h28A0, 1'b0, 1'b1, -1,
                '{err: 2'd3, ctrl: 1'b1, lat: 47, nwr: 4, data: 32'h78563412});
`endif

        // Reset at RX sample 9
        frame = {1'b0, 16'h28A0, 1'b0};
        ack_val = 1'b1;
        rb_corrupt = 1'b0;
        w0 = wr_total;
        @(negedge CLK);
        {ROMB1, ROMB0, RAMB, LAO} = 32'h11223344;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (15) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("midrst_busy", 32'(BUSY), 32'd0);
        chk("midrst_done", 32'(DONE), 32'd0);
        chk("midrst_cart_rstn", 32'(CART_RSTn), 32'd0);
        chk("midrst_ctrl", 32'(CTRL1_B7), 32'd0);
        chk("midrst_bus", 32'({CEn, SSn, WEn, OEn, ADDR, DQ_O, DQ_OE}), 32'({4'hF, 8'hFF, 8'h00, 1'b0}));
        repeat (50) @(negedge CLK);
        chk("midrst_no_writes", 32'(wr_total - w0), 32'd0);
        chk("midrst_idle", 32'(BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
